control: RTL and testbench
==========================

// Module: control
// PURPOSE
//  Main decoder for the single-cycle RV32I core. Maps instr_in to ALU op, register-file,
//  instruction-ROM, branch, data-RAM and datapath-mux controls. Handles program-load
//  (setup) mode, then restarts the PC cleanly when setup deasserts.
//  Decode is combinational. Only the setup/boot sequencing is clocked.
// PARAMETERS
//  none
// PORTS
//  clk                      in   1  system clock, rising edge
//  rst_n                    in   1  asynchronous, active-low reset
//  instr_in                 in   32 current instruction
//  setup                    in   1  1 = program-load mode (IROM being written)
//  ALU_OP                   out  5  ALU operation code (table below)
//  REG_write_en             out  1  write rd
//  IROM_write_en            out  1  IROM write strobe (load mode)
//  IROM_read_en             out  1  IROM fetch enable
//  BR_type                  out  2  00 none, 01 cond branch, 10 JAL, 11 JALR
//  PC_is_stall              out  1  hold PC
//  PC_is_writing_first_addr out  1  load PC with reset vector
//  RAM_write_en             out  1  store
//  RAM_read_en              out  1  load
//  RAM_ram_type             out  4  byte mask: 0001 B, 0011 H, 1111 W, 0000 none
//  RAM_sign                 out  1  1 = sign-extend load data (LB/LH/LW), 0 = LBU/LHU
//  MUX_op1_select           out  1  0 rs1, 1 PC
//  MUX_op2_select           out  1  0 rs2, 1 immediate
//  MUX_br_ret_addr_select   out  1  1 = PC+4 return path active (JAL/JALR)
//  MUX_br_Addr_sel          out  1  branch target: 0 PC+imm, 1 rs1+imm (JALR)
//  MUX_writeback            out  2  00 ALU, 01 RAM data, 10 PC+4, 11 immediate (LUI)
// BEHAVIOUR
//  - ALU_OP codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9,
//    BEQ 11, BNE 12, BLT 13, BGE 14, BLTU 15, BGEU 16. Values 10 and 17-31 are unused.
//  - R-type (0110011): ALU_OP from funct3; funct7[5] selects SUB/SRA; REG_write_en=1;
//    op2=rs2; wb=00.
//  - I-ALU (0010011): same map with op2=imm; funct7[5] is honoured only for SRAI.
//    ADDI never decodes as SUB.
//  - LUI (0110111): REG_write_en=1, wb=11, ALU_OP=ADD.
//  - AUIPC (0010111): op1=PC, op2=imm, ADD, REG_write_en=1, wb=00.
//  - JAL (1101111): BR_type=10, Addr_sel=0, ret_sel=1, wb=10, REG_write_en=1.
//  - JALR (1100111): BR_type=11, Addr_sel=1, ret_sel=1, wb=10, REG_write_en=1, op2=imm.
//  - Branch (1100011): BR_type=01, ALU_OP=BEQ..BGEU by funct3 (000,001,100,101,110,111),
//    op2=rs2, REG_write_en=0.
//  - Load (0000011): RAM_read_en=1, ADD, op2=imm, wb=01, REG_write_en=1.
//    Type/sign by funct3: 000 B/1, 001 H/1, 010 W/1, 100 B/0, 101 H/0.
//  - Store (0100011): RAM_write_en=1, ADD, op2=imm, REG_write_en=0.
//    Type by funct3: 000 B, 001 H, 010 W.
//  - Illegal opcode or funct3 behaves as a NOP: all enables 0, BR_type=00, muxes 0,
//    ALU_OP=ADD.
//  - Defaults whenever a field is not listed above: 0, or ADD for ALU_OP.
//  - setup=1 (async to decode, combinational):
//    - IROM_write_en=1, IROM_read_en=0, PC_is_stall=1.
//    - REG/RAM enables and BR_type forced to 0.
//  - setup=0: IROM_read_en=1 and IROM_write_en=0.
//  - Boot flag boot_q: set on rst_n low or while setup=1; cleared on the first clk
//    edge with setup=0.
//    - While boot_q=1 and setup=0: PC_is_writing_first_addr=1, PC_is_stall=0, and all
//      write enables are forced to 0.
//    - Net effect: exactly one cycle of first-address load after setup falls or after
//      reset release.
//  - rst_n=0 (async): boot_q=1; PC_is_stall=1; all write/read enables 0;
//    PC_is_writing_first_addr=0.
//  - Mid-operation reset re-enters the boot sequence.
//  - setup re-asserted mid-run returns to load mode immediately.
// TESTING
//  1. rst_n=1, setup=0, boot done. instr 0x1E027413 (ANDI) -> ALU_OP=9, op2_sel=1,
//     REG_write_en=1, wb=00.
//  2. 0x40648233 (SUB) -> ALU_OP=1, op2_sel=0, REG_write_en=1.
//     0x00000737 (LUI) -> wb=11. 0x00000097 (AUIPC) -> op1_sel=1, op2_sel=1, ALU_OP=0.
//  3. 0x000008EF (JAL) -> BR_type=10, wb=10, ret_sel=1, Addr_sel=0.
//     0x206C44E3 (BLT) -> BR_type=01, ALU_OP=13, REG_write_en=0.
//  4. 0x00002003 (LW) -> RAM_read_en=1, RAM_ram_type=1111, RAM_sign=1, wb=01.
//     0x00000023 (SB) -> RAM_write_en=1, RAM_ram_type=0001, REG_write_en=0.
//  5. setup=1 with an R-type instruction -> IROM_write_en=1, IROM_read_en=0,
//     PC_is_stall=1, REG_write_en=0. Drop setup -> PC_is_writing_first_addr=1 for
//     exactly one clk, then normal decode.
//  6. Pulse rst_n low mid-run -> enables 0 immediately, then one boot cycle.
//     Opcode 0x7F -> NOP outputs.

Source files
------------

// File: rtl/control.sv
// Main decoder for the single-cycle RV32I core.
// Combinational decode plus a one-flop boot sequencer.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   instr_in                 current instruction
//   setup                    1 = program-load mode
//   ALU_OP                   ALU operation code
//   REG_write_en             write rd
//   IROM_write_en            IROM write strobe
//   IROM_read_en             IROM fetch enable
//   BR_type                  00 none, 01 cond, 10 JAL, 11 JALR
//   PC_is_stall              hold PC
//   PC_is_writing_first_addr load PC with reset vector
//   RAM_write_en             store
//   RAM_read_en              load
//   RAM_ram_type             byte mask
//   RAM_sign                 sign-extend load data
//   MUX_op1_select           0 rs1, 1 PC
//   MUX_op2_select           0 rs2, 1 immediate
//   MUX_br_ret_addr_select   PC+4 return path
//   MUX_br_Addr_sel          0 PC+imm, 1 rs1+imm
//   MUX_writeback            00 ALU, 01 RAM, 10 PC+4, 11 imm
module control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr_in,
   input  logic        setup,
   output logic [4:0]  ALU_OP,
   output logic        REG_write_en,
   output logic        IROM_write_en,
   output logic        IROM_read_en,
   output logic [1:0]  BR_type,
   output logic        PC_is_stall,
   output logic        PC_is_writing_first_addr,
   output logic        RAM_write_en,
   output logic        RAM_read_en,
   output logic [3:0]  RAM_ram_type,
   output logic        RAM_sign,
   output logic        MUX_op1_select,
   output logic        MUX_op2_select,
   output logic        MUX_br_ret_addr_select,
   output logic        MUX_br_Addr_sel,
   output logic [1:0]  MUX_writeback
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SLT  = 5'd3;
   localparam logic [4:0] ALU_SLTU = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_AND  = 5'd9;
   localparam logic [4:0] ALU_BEQ  = 5'd11;
   localparam logic [4:0] ALU_BNE  = 5'd12;
   localparam logic [4:0] ALU_BLT  = 5'd13;
   localparam logic [4:0] ALU_BGE  = 5'd14;
   localparam logic [4:0] ALU_BLTU = 5'd15;
   localparam logic [4:0] ALU_BGEU = 5'd16;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_BOOT = 1'b1
   } boot_e;

   boot_e state_q;
   boot_e state_d;
   logic  boot_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       alt;

   logic [4:0] d_alu;
   logic       d_reg_we;
   logic [1:0] d_br;
   logic       d_ram_we;
   logic       d_ram_re;
   logic [3:0] d_ram_type;
   logic       d_sign;
   logic       d_op1;
   logic       d_op2;
   logic       d_ret;
   logic       d_addr;
   logic [1:0] d_wb;

   logic unused_instr_bits;

   assign opcode = instr_in[6:0];
   assign funct3 = instr_in[14:12];
   assign alt    = instr_in[30];

   assign unused_instr_bits = ^{instr_in[31],
                                instr_in[29:15],
                                instr_in[11:7]};

   // Shared R/I ALU map; alt picks SUB/SRA.
   function automatic logic [4:0] alu_map(
      input logic [2:0] f3,
      input logic       sub_sra
   );
      logic [4:0] op;
      op = ALU_ADD;
      case (f3)
         3'b000: op = sub_sra ? ALU_SUB : ALU_ADD;
         3'b001: op = ALU_SLL;
         3'b010: op = ALU_SLT;
         3'b011: op = ALU_SLTU;
         3'b100: op = ALU_XOR;
         3'b101: op = sub_sra ? ALU_SRA : ALU_SRL;
         3'b110: op = ALU_OR;
         3'b111: op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // Boot flag: held set through reset and load
   // mode, clears on the first edge with setup low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_BOOT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (setup) state_d = ST_BOOT;
      else       state_d = ST_RUN;
   end

   assign boot_q = (state_q == ST_BOOT);

   always_comb begin
      d_alu      = ALU_ADD;
      d_reg_we   = 1'b0;
      d_br       = 2'b00;
      d_ram_we   = 1'b0;
      d_ram_re   = 1'b0;
      d_ram_type = 4'b0000;
      d_sign     = 1'b0;
      d_op1      = 1'b0;
      d_op2      = 1'b0;
      d_ret      = 1'b0;
      d_addr     = 1'b0;
      d_wb       = 2'b00;
      case (opcode)
         OP_R: begin
            d_alu    = alu_map(funct3, alt);
            d_reg_we = 1'b1;
         end
         OP_I: begin
            // Only SRAI honours bit 30; ADDI
            // immediates must not turn into SUB.
            d_alu    = alu_map(funct3,
                          alt && (funct3 == 3'b101));
            d_reg_we = 1'b1;
            d_op2    = 1'b1;
         end
         OP_LUI: begin
            d_reg_we = 1'b1;
            d_wb     = 2'b11;
         end
         OP_AUIPC: begin
            d_reg_we = 1'b1;
            d_op1    = 1'b1;
            d_op2    = 1'b1;
         end
         OP_JAL: begin
            d_br     = 2'b10;
            d_ret    = 1'b1;
            d_wb     = 2'b10;
            d_reg_we = 1'b1;
         end
         OP_JALR: begin
            if (funct3 == 3'b000) begin
               d_br     = 2'b11;
               d_addr   = 1'b1;
               d_ret    = 1'b1;
               d_wb     = 2'b10;
               d_reg_we = 1'b1;
               d_op2    = 1'b1;
            end
         end
         OP_BR: begin
            case (funct3)
               3'b000: d_alu = ALU_BEQ;
               3'b001: d_alu = ALU_BNE;
               3'b100: d_alu = ALU_BLT;
               3'b101: d_alu = ALU_BGE;
               3'b110: d_alu = ALU_BLTU;
               3'b111: d_alu = ALU_BGEU;
               default: d_alu = ALU_ADD;
            endcase
            if (d_alu != ALU_ADD) d_br = 2'b01;
         end
         OP_LD: begin
            case (funct3)
               3'b000: begin
                  d_ram_type = MASK_B;
                  d_sign     = 1'b1;
               end
               3'b001: begin
                  d_ram_type = MASK_H;
                  d_sign     = 1'b1;
               end
               3'b010: begin
                  d_ram_type = MASK_W;
                  d_sign     = 1'b1;
               end
               3'b100: d_ram_type = MASK_B;
               3'b101: d_ram_type = MASK_H;
               default: d_ram_type = 4'b0000;
            endcase
            if (d_ram_type != 4'b0000) begin
               d_ram_re = 1'b1;
               d_op2    = 1'b1;
               d_wb     = 2'b01;
               d_reg_we = 1'b1;
            end
         end
         OP_ST: begin
            case (funct3)
               3'b000:  d_ram_type = MASK_B;
               3'b001:  d_ram_type = MASK_H;
               3'b010:  d_ram_type = MASK_W;
               default: d_ram_type = 4'b0000;
            endcase
            if (d_ram_type != 4'b0000) begin
               d_ram_we = 1'b1;
               d_op2    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Mode gating: reset beats load mode, which
   // beats the one-cycle first-address load.
   always_comb begin
      ALU_OP                   = d_alu;
      REG_write_en             = d_reg_we;
      IROM_write_en            = 1'b0;
      IROM_read_en             = 1'b1;
      BR_type                  = d_br;
      PC_is_stall              = 1'b0;
      PC_is_writing_first_addr = 1'b0;
      RAM_write_en             = d_ram_we;
      RAM_read_en              = d_ram_re;
      RAM_ram_type             = d_ram_type;
      RAM_sign                 = d_sign;
      MUX_op1_select           = d_op1;
      MUX_op2_select           = d_op2;
      MUX_br_ret_addr_select   = d_ret;
      MUX_br_Addr_sel          = d_addr;
      MUX_writeback            = d_wb;
      if (!rst_n) begin
         PC_is_stall   = 1'b1;
         REG_write_en  = 1'b0;
         IROM_write_en = 1'b0;
         IROM_read_en  = 1'b0;
         RAM_write_en  = 1'b0;
         RAM_read_en   = 1'b0;
      end else if (setup) begin
         IROM_write_en = 1'b1;
         IROM_read_en  = 1'b0;
         PC_is_stall   = 1'b1;
         REG_write_en  = 1'b0;
         RAM_write_en  = 1'b0;
         RAM_read_en   = 1'b0;
         BR_type       = 2'b00;
      end else if (boot_q) begin
         PC_is_writing_first_addr = 1'b1;
         REG_write_en             = 1'b0;
         RAM_write_en             = 1'b0;
      end
   end

endmodule

// File: tb/tb_control.sv
// Directed scoreboard bench for control.
// Expected bundles are queued then popped on compare.
module tb_control;

   typedef struct packed {
      logic [4:0] alu;
      logic       reg_we;
      logic       irom_we;
      logic       irom_re;
      logic [1:0] br;
      logic       stall;
      logic       first;
      logic       ram_we;
      logic       ram_re;
      logic [3:0] ram_type;
      logic       sign;
      logic       op1;
      logic       op2;
      logic       ret;
      logic       addr;
      logic [1:0] wb;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr_in;
   logic        setup;
   exp_t        obs;

   exp_t  sb_q[$];
   string tag_q[$];
   int    checks;
   int    failures;

   control dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .instr_in                 (instr_in),
      .setup                    (setup),
      .ALU_OP                   (obs.alu),
      .REG_write_en             (obs.reg_we),
      .IROM_write_en            (obs.irom_we),
      .IROM_read_en             (obs.irom_re),
      .BR_type                  (obs.br),
      .PC_is_stall              (obs.stall),
      .PC_is_writing_first_addr (obs.first),
      .RAM_write_en             (obs.ram_we),
      .RAM_read_en              (obs.ram_re),
      .RAM_ram_type             (obs.ram_type),
      .RAM_sign                 (obs.sign),
      .MUX_op1_select           (obs.op1),
      .MUX_op2_select           (obs.op2),
      .MUX_br_ret_addr_select   (obs.ret),
      .MUX_br_Addr_sel          (obs.addr),
      .MUX_writeback            (obs.wb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   // Normal-run NOP: only the fetch enable is high.
   function automatic exp_t run_nop();
      exp_t e;
      e = '0;
      e.irom_re = 1'b1;
      return e;
   endfunction

   task automatic check();
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s obs=%h exp=%h", t, obs, e);
      end
   endtask

   // Drive at the falling edge, compare 1 ns later.
   task automatic apply(input logic [31:0] i,
                        input logic s,
                        input logic r,
                        input exp_t e,
                        input string t);
      @(negedge clk);
      instr_in = i;
      setup    = s;
      rst_n    = r;
      sb_q.push_back(e);
      tag_q.push_back(t);
      #1;
      check();
   endtask

   task automatic after_edge(input exp_t e,
                             input string t);
      @(posedge clk);
      sb_q.push_back(e);
      tag_q.push_back(t);
      #1;
      check();
   endtask

   initial begin
      exp_t e;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      setup    = 1'b0;
      instr_in = 32'h0;

      e = '0;
      e.stall = 1'b1;
      sb_q.push_back(e);
      tag_q.push_back("reset");
      #1;
      check();

      e = run_nop();
      e.first = 1'b1;
      apply(32'h0, 1'b0, 1'b1, e, "rst_release_boot");
      after_edge(run_nop(), "boot_done");

      e = run_nop();
      e.alu = 5'd9; e.op2 = 1'b1; e.reg_we = 1'b1;
      apply(32'h1E027413, 1'b0, 1'b1, e, "andi");

      e = run_nop();
      e.alu = 5'd1; e.reg_we = 1'b1;
      apply(32'h40648233, 1'b0, 1'b1, e, "sub");

      e = run_nop();
      e.reg_we = 1'b1; e.wb = 2'b11;
      apply(32'h00000737, 1'b0, 1'b1, e, "lui");

      e = run_nop();
      e.reg_we = 1'b1; e.op1 = 1'b1; e.op2 = 1'b1;
      apply(32'h00000097, 1'b0, 1'b1, e, "auipc");

      e = run_nop();
      e.reg_we = 1'b1; e.br = 2'b10;
      e.ret = 1'b1; e.wb = 2'b10;
      apply(32'h000008EF, 1'b0, 1'b1, e, "jal");

      e = run_nop();
      e.reg_we = 1'b1; e.br = 2'b11; e.addr = 1'b1;
      e.ret = 1'b1; e.wb = 2'b10; e.op2 = 1'b1;
      apply(32'h00008067, 1'b0, 1'b1, e, "jalr");

      e = run_nop();
      e.alu = 5'd13; e.br = 2'b01;
      apply(32'h206C44E3, 1'b0, 1'b1, e, "blt");

      e = run_nop();
      e.alu = 5'd16; e.br = 2'b01;
      apply(32'h0000F063, 1'b0, 1'b1, e, "bgeu");

      apply(32'h00002063, 1'b0, 1'b1, run_nop(),
            "br_bad_f3");

      e = run_nop();
      e.ram_re = 1'b1; e.ram_type = 4'b1111;
      e.sign = 1'b1; e.wb = 2'b01;
      e.reg_we = 1'b1; e.op2 = 1'b1;
      apply(32'h00002003, 1'b0, 1'b1, e, "lw");

      e = run_nop();
      e.ram_re = 1'b1; e.ram_type = 4'b0011;
      e.wb = 2'b01; e.reg_we = 1'b1; e.op2 = 1'b1;
      apply(32'h00005003, 1'b0, 1'b1, e, "lhu");

      e = run_nop();
      e.ram_we = 1'b1; e.ram_type = 4'b0001;
      e.op2 = 1'b1;
      apply(32'h00000023, 1'b0, 1'b1, e, "sb");

      e = run_nop();
      e.ram_we = 1'b1; e.ram_type = 4'b0011;
      e.op2 = 1'b1;
      apply(32'h00001023, 1'b0, 1'b1, e, "sh");

      e = run_nop();
      e.alu = 5'd7; e.op2 = 1'b1; e.reg_we = 1'b1;
      apply(32'h40525293, 1'b0, 1'b1, e, "srai");

      e = run_nop();
      e.alu = 5'd0; e.op2 = 1'b1; e.reg_we = 1'b1;
      apply(32'h40000013, 1'b0, 1'b1, e, "addi_b30");

      apply(32'h0000007F, 1'b0, 1'b1, run_nop(),
            "illegal_op");

      e = '0;
      e.alu = 5'd1; e.irom_we = 1'b1; e.stall = 1'b1;
      apply(32'h40648233, 1'b1, 1'b1, e, "setup_on");
      after_edge(e, "setup_hold");

      e = '0;
      e.alu = 5'd1; e.irom_re = 1'b1; e.first = 1'b1;
      apply(32'h40648233, 1'b0, 1'b1, e, "setup_drop");

      e = run_nop();
      e.alu = 5'd1; e.reg_we = 1'b1;
      after_edge(e, "post_setup");
      after_edge(e, "post_setup2");

      e = '0;
      e.stall = 1'b1; e.ram_type = 4'b0001;
      e.op2 = 1'b1;
      apply(32'h00000023, 1'b0, 1'b0, e, "mid_reset");
      after_edge(e, "reset_hold");

      e = run_nop();
      e.first = 1'b1; e.ram_type = 4'b0001;
      e.op2 = 1'b1;
      apply(32'h00000023, 1'b0, 1'b1, e, "reset_boot");

      e = run_nop();
      e.ram_we = 1'b1; e.ram_type = 4'b0001;
      e.op2 = 1'b1;
      after_edge(e, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
